uart_tx_frame_ctrl: RTL and testbench

- Upstream feeder for the UART Tx serializer (PISO).
- Accepts bytes on a valid/ready handshake, holds them in a one-entry buffer, and latches the line configuration with each byte.
- Assembles the Bits-wide LSB-first frame and computes the parity bit.
- Generates BaudOut from the system clock, and drives Send/FrameOut so the serializer always samples stable values on BaudOut rising edges. Supports back-to-back frames.

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_baud_div.sv | 36 +++
 rtl/uart_tx_frame_ctrl.sv | 143 ++++++++++++++
 tb/tb_uart_tx_frame_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: parity encodings, controller states and
// frame assembly.
package uart_pkg;

  localparam logic [1:0] PAR_NONE0 = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE3 = 2'b11;

  // Widest frame the assembler produces: start + 8 data + parity + 2 stop.
  localparam int unsigned MaxFrameW = 12;

  typedef enum logic {
    StIdle = 1'b0,
    StSend = 1'b1
  } txState_e;

  // LSB-first frame: start bit at position 0, then data, optional parity, stop bits, idle ones.
  function automatic logic [MaxFrameW-1:0] assembleFrame(input logic [7:0] data,
                                                         input logic       len,
                                                         input logic [1:0] ptype,
                                                         input logic       stop);
    logic       parEn;
    logic       parBit;
    logic [1:0] tail;
    logic [MaxFrameW-1:0] frame;
    parEn  = (ptype == PAR_ODD) || (ptype == PAR_EVEN);
    parBit = (ptype == PAR_ODD) ? ~^(len ? data : {1'b0, data[6:0]})
                                :  ^(len ? data : {1'b0, data[6:0]});
    // Second stop bit, or an idle mark when only one stop is requested: both are 1.
    tail   = {stop, 1'b1} | {~stop, 1'b0};
    if (len) begin
      frame = parEn ? {tail, parBit, data, 1'b0} : {1'b1, tail, data, 1'b0};
    end else begin
      frame = parEn ? {1'b1, tail, parBit, data[6:0], 1'b0}
                    : {2'b11, tail, data[6:0], 1'b0};
    end
    return frame;
  endfunction

endpackage

// File: rtl/uart_baud_div.sv
// Free-running baud divider: 50% duty BaudOut plus single-cycle strobes marking the Clk edge
// on which BaudOut rises (Rise) and falls (Fall).
module uart_baud_div #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic Clk,
  input  logic ResetN,
  output logic BaudOut,
  output logic Rise,
  output logic Fall
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntLast    = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntHalf    = CntW'(CLK_DIV / 2);
  localparam logic [CntW-1:0] CntPreHalf = CntW'(CLK_DIV / 2 - 1);

  logic [CntW-1:0] cntQ, cntD;

  always_comb begin
    cntD = (cntQ == CntLast) ? '0 : cntQ + 1'b1;
    Rise = (cntQ == CntPreHalf);
    Fall = (cntQ == CntLast);
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      cntQ    <= '0;
      BaudOut <= 1'b0;
    end else begin
      cntQ    <= cntD;
      BaudOut <= (cntD >= CntHalf);
    end
  end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit front end: one-entry byte buffer, frame assembly and Send/FrameOut sequencing
// aligned to the falling edge of the generated baud clock.
module uart_tx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned Bits    = 11,
  parameter int unsigned CLK_DIV = 16
) (
  input  logic            Clk,
  input  logic            ResetN,
  input  logic [7:0]      TxData,
  input  logic            TxValid,
  output logic            TxReady,
  input  logic [1:0]      ParityTypeIn,
  input  logic            StopBitsIn,
  input  logic            DataLengthIn,
  output logic            BaudOut,
  output logic            Send,
  output logic [Bits-1:0] FrameOut,
  output logic            ParityOut,
  output logic [1:0]      ParityType,
  output logic            StopBits,
  output logic            DataLength,
  output logic            Busy
);

  localparam int unsigned EdgeW = $clog2(Bits + 1);
  localparam logic [EdgeW-1:0] EdgeMax = EdgeW'(Bits);
  localparam int unsigned CopyW = (Bits < MaxFrameW) ? Bits : MaxFrameW;

  logic baudRise, baudFall;

  uart_baud_div #(
    .CLK_DIV(CLK_DIV)
  ) uBaudDiv (
    .Clk    (Clk),
    .ResetN (ResetN),
    .BaudOut(BaudOut),
    .Rise   (baudRise),
    .Fall   (baudFall)
  );

  logic       bufFullQ;
  logic [7:0] bufDataQ;
  logic [1:0] bufParQ;
  logic       bufStopQ;
  logic       bufLenQ;

  txState_e         stateQ, stateD;
  logic [EdgeW-1:0] edgeCntQ, edgeCntD;
  logic             load;

  logic [MaxFrameW-1:0] frameRaw;
  logic [Bits-1:0]      frameNext;
  logic                 parityNext;

  assign TxReady = ~bufFullQ;
  assign Send    = (stateQ == StSend);
  assign Busy    = (stateQ == StSend);

  // Positions beyond the assembled frame idle at 1; positions beyond Bits are dropped.
  always_comb begin
    frameRaw                = assembleFrame(bufDataQ, bufLenQ, bufParQ, bufStopQ);
    frameNext               = '1;
    frameNext[CopyW-1:0]    = frameRaw[CopyW-1:0];
    parityNext              = bufLenQ ? ~^bufDataQ : ~^bufDataQ[6:0];
  end

  always_comb begin
    stateD   = stateQ;
    edgeCntD = edgeCntQ;
    load     = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (baudFall && bufFullQ) begin
          load     = 1'b1;
          edgeCntD = '0;
          stateD   = StSend;
        end
      end
      StSend: begin
        if (baudRise && (edgeCntQ < EdgeMax)) begin
          edgeCntD = edgeCntQ + 1'b1;
        end
        if (baudFall && (edgeCntQ == EdgeMax)) begin
          if (bufFullQ) begin
            load     = 1'b1;
            edgeCntD = '0;
          end else begin
            stateD   = StIdle;
          end
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      stateQ   <= StIdle;
      edgeCntQ <= '0;
    end else begin
      stateQ   <= stateD;
      edgeCntQ <= edgeCntD;
    end
  end

  // A launch drains the buffer; the slot reopens on the following cycle.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      bufFullQ <= 1'b0;
      bufDataQ <= '0;
      bufParQ  <= '0;
      bufStopQ <= 1'b0;
      bufLenQ  <= 1'b0;
    end else if (load) begin
      bufFullQ <= 1'b0;
    end else if (TxValid && !bufFullQ) begin
      bufFullQ <= 1'b1;
      bufDataQ <= TxData;
      bufParQ  <= ParityTypeIn;
      bufStopQ <= StopBitsIn;
      bufLenQ  <= DataLengthIn;
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      FrameOut   <= '1;
      ParityOut  <= 1'b0;
      ParityType <= PAR_NONE0;
      StopBits   <= 1'b0;
      DataLength <= 1'b0;
    end else if (load) begin
      FrameOut   <= frameNext;
      ParityOut  <= parityNext;
      ParityType <= bufParQ;
      StopBits   <= bufStopQ;
      DataLength <= bufLenQ;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: directed and random bytes checked against a frame model, plus
// a CLK_DIV=4 instance checked for baud clock shape and output stability at rising edges.
module tb_uart_tx_frame_ctrl;

  localparam int unsigned Bits = 11;
  localparam int unsigned Div  = 16;
  localparam int unsigned Div4 = 4;

  typedef struct packed {
    logic [Bits-1:0] frame;
    logic            par;
    logic [1:0]      pt;
    logic            sb;
    logic            dl;
  } rec_t;

  logic            Clk = 1'b0;
  logic            ResetN;
  logic [7:0]      TxData;
  logic            TxValid;
  logic [1:0]      ParityTypeIn;
  logic            StopBitsIn;
  logic            DataLengthIn;
  logic            TxReady, BaudOut, Send, ParityOut, StopBits, DataLength, Busy;
  logic [Bits-1:0] FrameOut;
  logic [1:0]      ParityType;
  logic            TxReady4, BaudOut4, Send4, ParityOut4, StopBits4, DataLength4, Busy4;
  logic [Bits-1:0] FrameOut4;
  logic [1:0]      ParityType4;

  int checks = 0;
  int errors = 0;
  int riseBad = 0;
  int baud4Bad = 0;
  int edges4 = 0;

  rec_t expQ[$];
  rec_t obsQ[$];
  int   riseQ[$];
  bit   b2bQ[$];

  always #5 Clk = ~Clk;

  uart_tx_frame_ctrl #(.Bits(Bits), .CLK_DIV(Div)) dut (
    .Clk(Clk), .ResetN(ResetN), .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
    .ParityTypeIn(ParityTypeIn), .StopBitsIn(StopBitsIn), .DataLengthIn(DataLengthIn),
    .BaudOut(BaudOut), .Send(Send), .FrameOut(FrameOut), .ParityOut(ParityOut),
    .ParityType(ParityType), .StopBits(StopBits), .DataLength(DataLength), .Busy(Busy)
  );

  uart_tx_frame_ctrl #(.Bits(Bits), .CLK_DIV(Div4)) dut4 (
    .Clk(Clk), .ResetN(ResetN), .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady4),
    .ParityTypeIn(ParityTypeIn), .StopBitsIn(StopBitsIn), .DataLengthIn(DataLengthIn),
    .BaudOut(BaudOut4), .Send(Send4), .FrameOut(FrameOut4), .ParityOut(ParityOut4),
    .ParityType(ParityType4), .StopBits(StopBits4), .DataLength(DataLength4), .Busy(Busy4)
  );

  // Frame built arithmetically: data shifted past the start bit, parity, then all ones above.
  function automatic rec_t refRec(input logic [7:0] d, input logic [1:0] pt, input logic sb,
                                  input logic dl);
    int          n, pos, ones;
    int unsigned dv, v;
    rec_t        r;
    n    = dl ? 8 : 7;
    dv   = 32'(d) & ((32'd1 << n) - 32'd1);
    ones = $countones(dv);
    v    = dv << 1;
    pos  = n + 1;
    if (pt == 2'b01) begin
      v = v | (32'((ones % 2) == 0) << pos);
      pos++;
    end else if (pt == 2'b10) begin
      v = v | (32'(ones % 2) << pos);
      pos++;
    end
    v       = v | (32'hFFFF_FFFF << pos);
    r.frame = v[Bits-1:0];
    r.par   = ((ones % 2) == 0);
    r.pt    = pt;
    r.sb    = sb;
    r.dl    = dl;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame monitor: records each launched frame and the BaudOut rises seen while Send was high.
  logic            pBaud, pSend;
  logic [Bits-1:0] pFrame;
  int              rises;
  always begin
    @(posedge Clk);
    #1;
    if (ResetN !== 1'b1) begin
      pBaud  = 1'b0;
      pSend  = 1'b0;
      pFrame = '1;
      rises  = 0;
    end else begin
      if (BaudOut && !pBaud) begin
        if (Send !== pSend || FrameOut !== pFrame) riseBad++;
        if (Send) rises++;
      end
      if (!BaudOut && pBaud) begin
        if (Send && (!pSend || rises == Bits)) begin
          if (pSend) riseQ.push_back(rises);
          obsQ.push_back(rec_t'({FrameOut, ParityOut, ParityType, StopBits, DataLength}));
          b2bQ.push_back(pSend);
          rises = 0;
        end else if (!Send && pSend) begin
          riseQ.push_back(rises);
          rises = 0;
        end
      end
      pBaud  = BaudOut;
      pSend  = Send;
      pFrame = FrameOut;
    end
  end

  // Fast-divider monitor: every BaudOut4 level lasts Div4/2 cycles after the first edge.
  logic            last4, started4, pSend4;
  logic [Bits-1:0] pFrame4;
  int              run4;
  always begin
    @(posedge Clk);
    #1;
    if (ResetN !== 1'b1) begin
      last4    = 1'b0;
      started4 = 1'b0;
      run4     = 0;
      pSend4   = 1'b0;
      pFrame4  = '1;
    end else begin
      if (BaudOut4 !== last4) begin
        if (started4 && run4 != int'(Div4 / 2)) baud4Bad++;
        if (BaudOut4 && (Send4 !== pSend4 || FrameOut4 !== pFrame4)) riseBad++;
        started4 = 1'b1;
        edges4++;
        run4  = 1;
        last4 = BaudOut4;
      end else begin
        run4++;
      end
      pSend4  = Send4;
      pFrame4 = FrameOut4;
    end
  end

  task automatic sendByte(input logic [7:0] d, input logic [1:0] pt, input logic sb,
                          input logic dl);
    bit ok;
    @(negedge Clk);
    TxData       = d;
    ParityTypeIn = pt;
    StopBitsIn   = sb;
    DataLengthIn = dl;
    TxValid      = 1'b1;
    for (int i = 0; i < 400 && TxReady !== 1'b1; i++) @(negedge Clk);
    ok = (TxReady === 1'b1);
    @(posedge Clk);
    @(negedge Clk);
    TxValid = 1'b0;
    check("accept_timeout", 32'(ok), 32'd1);
    if (ok) expQ.push_back(refRec(d, pt, sb, dl));
  endtask

  task automatic waitIdle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge Clk);
      if (Busy === 1'b0 && TxReady === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_timeout", 32'(ok), 32'd1);
  endtask

  task automatic compareAll(input string tag);
    rec_t o, e;
    check({tag, "_count"}, obsQ.size(), expQ.size());
    check({tag, "_rise_count"}, riseQ.size(), expQ.size());
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      o = obsQ.pop_front();
      e = expQ.pop_front();
      check({tag, "_frame"}, 32'(o.frame), 32'(e.frame));
      check({tag, "_parity"}, 32'(o.par), 32'(e.par));
      check({tag, "_cfg"}, 32'({o.pt, o.sb, o.dl}), 32'({e.pt, e.sb, e.dl}));
    end
    while (riseQ.size() > 0) check({tag, "_rises"}, riseQ.pop_front(), Bits);
    obsQ.delete();
    expQ.delete();
    b2bQ.delete();
  endtask

  task automatic clearQueues();
    obsQ.delete();
    expQ.delete();
    riseQ.delete();
    b2bQ.delete();
  endtask

  initial begin
    rec_t ra, rb;
    logic [Bits-1:0] prevFrame;
    bit got;

    ResetN       = 1'b0;
    TxData       = '0;
    TxValid      = 1'b0;
    ParityTypeIn = '0;
    StopBitsIn   = 1'b0;
    DataLengthIn = 1'b0;
    #12;
    check("rst_baud", 32'(BaudOut), 32'd0);
    check("rst_send", 32'(Send), 32'd0);
    check("rst_frame", 32'(FrameOut), 32'h7FF);
    check("rst_parity", 32'(ParityOut), 32'd0);
    check("rst_cfg", 32'({ParityType, StopBits, DataLength}), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_ready", 32'(TxReady), 32'd1);
    @(negedge Clk);
    ResetN = 1'b1;

    // Abort a frame in flight with a second byte buffered.
    sendByte(8'h33, 2'b10, 1'b0, 1'b1);
    sendByte(8'hC3, 2'b01, 1'b1, 1'b1);
    repeat (20) @(negedge Clk);
    check("mid_busy", 32'(Busy), 32'd1);
    check("mid_ready", 32'(TxReady), 32'd0);
    #2;
    ResetN = 1'b0;
    #1;
    check("arst_send", 32'(Send), 32'd0);
    check("arst_busy", 32'(Busy), 32'd0);
    check("arst_frame", 32'(FrameOut), 32'h7FF);
    check("arst_baud", 32'(BaudOut), 32'd0);
    check("arst_ready", 32'(TxReady), 32'd1);
    @(negedge Clk);
    ResetN = 1'b1;
    clearQueues();
    repeat (40) @(negedge Clk);
    check("discarded_send", 32'(Send), 32'd0);

    sendByte(8'h55, 2'b10, 1'b0, 1'b1);
    waitIdle();
    if (obsQ.size() > 0) check("f55_frame", 32'(obsQ[0].frame), 32'h4AA);
    else check("f55_present", 32'd0, 32'd1);
    check("f55_send_low", 32'(Send), 32'd0);
    compareAll("f55");

    sendByte(8'h41, 2'b01, 1'b1, 1'b0);
    sendByte(8'hFF, 2'b11, 1'b1, 1'b1);
    waitIdle();
    if (obsQ.size() > 1) begin
      check("f41_frame", 32'(obsQ[0].frame), 32'h782);
      check("fff_frame", 32'(obsQ[1].frame), 32'h7FE);
    end else check("f41_fff_present", 32'd0, 32'd1);
    compareAll("pair");

    // Back-to-back frames, then a byte offered while the buffer is still full.
    ra = refRec(8'hA5, 2'b10, 1'b1, 1'b1);
    rb = refRec(8'h3C, 2'b10, 1'b1, 1'b1);
    sendByte(8'hA5, 2'b10, 1'b1, 1'b1);
    sendByte(8'h3C, 2'b10, 1'b1, 1'b1);
    check("full_ready", 32'(TxReady), 32'd0);
    TxData       = 8'h5A;
    ParityTypeIn = 2'b01;
    StopBitsIn   = 1'b0;
    DataLengthIn = 1'b0;
    TxValid      = 1'b1;
    prevFrame    = FrameOut;
    got          = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      if (TxReady === 1'b1) begin
        got = 1'b1;
        break;
      end
      prevFrame = FrameOut;
    end
    check("held_ready_rise", 32'(got), 32'd1);
    check("held_prev_frame", 32'(prevFrame), 32'(ra.frame));
    check("held_new_frame", 32'(FrameOut), 32'(rb.frame));
    check("held_send", 32'(Send), 32'd1);
    @(posedge Clk);
    @(negedge Clk);
    TxValid = 1'b0;
    if (got) expQ.push_back(refRec(8'h5A, 2'b01, 1'b0, 1'b0));
    check("held_accepted", 32'(TxReady), 32'd0);
    waitIdle();
    if (b2bQ.size() == 3) begin
      check("b2b_second", 32'(b2bQ[1]), 32'd1);
      check("b2b_third", 32'(b2bQ[2]), 32'd1);
    end else check("b2b_frames", b2bQ.size(), 3);
    compareAll("b2b");

    for (int k = 0; k < 20; k++) begin
      sendByte(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 300)) @(negedge Clk);
    end
    waitIdle();
    compareAll("rand");

    check("rise_stability", riseBad, 0);
    check("div4_shape", baud4Bad, 0);
    check("div4_activity", 32'(edges4 > 20), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
